cc_coef_loader: RTL and testbench

CC_COEF_LOADER -- requirements
Module: cc_coef_loader

---
 rtl/color_corrector_csr_pkg.sv | 23 ++
 rtl/axi4_lite_if.sv | 24 ++
 rtl/axi4_lite_wr_master.sv | 85 ++++++++
 rtl/cc_coef_loader.sv | 142 ++++++++++++++
 tb/tb_cc_coef_loader.sv | 307 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/color_corrector_csr_pkg.sv
// Colour-corrector CSR map plus shared types and defaults for the coefficient loader.
package color_corrector_csr_pkg;

  localparam int unsigned CC_CTRL_CR      = 0;
  localparam int unsigned CC_STATUS_CR    = 1;
  localparam int unsigned CC_COEF_LOCK_CR = 2;
  localparam int unsigned CC_COEF_SEL_CR  = 3;
  localparam int unsigned CC_COEF_CR      = 4;

  localparam int unsigned CC_COEF_CNT_DEF = 12;
  localparam int unsigned CC_TIMEOUT_DEF  = 1024;

  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

  typedef enum logic [2:0] {
    IDLE, LOCK_ON, SEL, COEF, LOCK_OFF, FIN
  } cc_ld_state_e;

  function automatic logic [31:0] cc_reg_addr(input logic [31:0] base, input int unsigned idx);
    return base + 32'(idx << 2);
  endfunction

endpackage

// File: rtl/axi4_lite_if.sv
// AXI4-Lite bundle, 32-bit address and data.
interface axi4_lite_if;
  logic [31:0] awaddr;
  logic        awvalid, awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid, wready;
  logic [1:0]  bresp;
  logic        bvalid, bready;
  logic [31:0] araddr;
  logic        arvalid, arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid, rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axi4_lite_wr_master.sv
// Single AXI4-Lite write: aw/w launched together, each dropped at its own handshake,
// then b accepted; a watchdog aborts the write if no response arrives in time.
module axi4_lite_wr_master #(
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_data,
  output logic        done,
  output logic [1:0]  resp,
  output logic        timeout,
  output logic [31:0] awaddr,
  output logic        awvalid,
  input  logic        awready,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wvalid,
  input  logic        wready,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready
);
  localparam int unsigned WD_W = $clog2(TIMEOUT + 1);

  logic            active, aw_done, w_done;
  logic [WD_W-1:0] wdog;
  logic            aw_hs, w_hs, b_hs;

  assign aw_hs     = awvalid & awready;
  assign w_hs      = wvalid & wready;
  assign b_hs      = bvalid & bready;
  assign cmd_ready = ~active;
  assign done      = b_hs;
  assign resp      = bresp;
  assign wstrb     = 4'hF;
  assign timeout   = active & ~b_hs & (wdog == WD_W'(TIMEOUT - 1));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      active  <= 1'b0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
      awvalid <= 1'b0;
      wvalid  <= 1'b0;
      bready  <= 1'b0;
      awaddr  <= '0;
      wdata   <= '0;
      wdog    <= '0;
    end else if (cmd_valid & cmd_ready) begin
      active  <= 1'b1;
      awaddr  <= cmd_addr;
      wdata   <= cmd_data;
      awvalid <= 1'b1;
      wvalid  <= 1'b1;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
      bready  <= 1'b0;
      wdog    <= '0;
    end else if (active) begin
      if (b_hs | timeout) begin
        // a timed-out write is abandoned outright so the sequencer can recover
        active  <= 1'b0;
        awvalid <= 1'b0;
        wvalid  <= 1'b0;
        bready  <= 1'b0;
        wdog    <= '0;
      end else begin
        wdog <= wdog + 1'b1;
        if (aw_hs) begin
          awvalid <= 1'b0;
          aw_done <= 1'b1;
        end
        if (w_hs) begin
          wvalid <= 1'b0;
          w_done <= 1'b1;
        end
        if ((aw_done | aw_hs) & (w_done | w_hs)) bready <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/cc_coef_loader.sv
// Loads COEF_CNT colour-correction coefficients through the CSR window:
// LOCK=1, {SEL=i, COEF=coef_i} per index, LOCK=0, then a done pulse.
module cc_coef_loader
  import color_corrector_csr_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned COEF_CNT  = CC_COEF_CNT_DEF,
  parameter int unsigned TIMEOUT   = CC_TIMEOUT_DEF
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  output logic [3:0]  coef_idx_o,
  input  logic [31:0] coef_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  axi4_lite_if.master csr_o
);
  cc_ld_state_e state, nxt;
  logic [3:0]   idx;
  logic         err, issued;
  logic         cmd_valid, cmd_ready;
  logic [31:0]  cmd_addr, cmd_data;
  logic         wr_done, wr_tmo, wr_fail, wr_end, last;
  logic [1:0]   wr_resp;
  logic [31:0]  awaddr, wdata;
  logic [3:0]   wstrb;
  logic         awvalid, wvalid, bready, awready, wready, bvalid;
  logic [1:0]   bresp;

  assign wr_end  = wr_done | wr_tmo;
  assign wr_fail = (wr_done & (wr_resp != AXI_RESP_OKAY)) | wr_tmo;
  assign last    = (idx == 4'(COEF_CNT - 1));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:     if (start_i) nxt = LOCK_ON;
      LOCK_ON:  if (wr_end) nxt = wr_fail ? LOCK_OFF : SEL;
      SEL:      if (wr_end) nxt = wr_fail ? LOCK_OFF : COEF;
      COEF:     if (wr_end) nxt = (wr_fail | last) ? LOCK_OFF : SEL;
      LOCK_OFF: if (wr_end) nxt = FIN;
      FIN:      nxt = IDLE;
      default:  nxt = IDLE;
    endcase
  end

  always_comb begin
    cmd_valid = 1'b0;
    cmd_addr  = BASE_ADDR;
    cmd_data  = '0;
    busy_o    = (state != IDLE);
    done_o    = (state == FIN);
    case (state)
      LOCK_ON: begin
        cmd_valid = ~issued;
        cmd_addr  = cc_reg_addr(BASE_ADDR, CC_COEF_LOCK_CR);
        cmd_data  = 32'd1;
      end
      SEL: begin
        cmd_valid = ~issued;
        cmd_addr  = cc_reg_addr(BASE_ADDR, CC_COEF_SEL_CR);
        cmd_data  = {28'd0, idx};
      end
      COEF: begin
        cmd_valid = ~issued;
        cmd_addr  = cc_reg_addr(BASE_ADDR, CC_COEF_CR);
        cmd_data  = coef_i;
      end
      LOCK_OFF: begin
        cmd_valid = ~issued;
        cmd_addr  = cc_reg_addr(BASE_ADDR, CC_COEF_LOCK_CR);
        cmd_data  = '0;
      end
      default: ;
    endcase
  end

  // issued keeps one command per state; idx only advances after a good COEF write
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      idx    <= '0;
      err    <= 1'b0;
      issued <= 1'b0;
    end else begin
      if (cmd_valid & cmd_ready) issued <= 1'b1;
      else if (wr_end)           issued <= 1'b0;
      if ((state == IDLE) & start_i) begin
        idx <= '0;
        err <= 1'b0;
      end
      if (wr_fail) err <= 1'b1;
      if ((state == COEF) & wr_done & ~wr_fail & ~last) idx <= idx + 4'd1;
    end
  end

  assign coef_idx_o = idx;
  assign err_o      = err;

  axi4_lite_wr_master #(.TIMEOUT(TIMEOUT)) u_wr (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_addr (cmd_addr),
    .cmd_data (cmd_data),
    .done     (wr_done),
    .resp     (wr_resp),
    .timeout  (wr_tmo),
    .awaddr   (awaddr),
    .awvalid  (awvalid),
    .awready  (awready),
    .wdata    (wdata),
    .wstrb    (wstrb),
    .wvalid   (wvalid),
    .wready   (wready),
    .bresp    (bresp),
    .bvalid   (bvalid),
    .bready   (bready)
  );

  assign csr_o.awaddr  = awaddr;
  assign csr_o.awvalid = awvalid;
  assign csr_o.wdata   = wdata;
  assign csr_o.wstrb   = wstrb;
  assign csr_o.wvalid  = wvalid;
  assign csr_o.bready  = bready;
  assign awready       = csr_o.awready;
  assign wready        = csr_o.wready;
  assign bvalid        = csr_o.bvalid;
  assign bresp         = csr_o.bresp;
  assign csr_o.arvalid = 1'b0;
  assign csr_o.araddr  = '0;
  assign csr_o.rready  = 1'b1;

endmodule

// File: tb/tb_cc_coef_loader.sv
// Scoreboarded bench: directed sequences against a configurable AXI4-Lite slave model.
module tb_cc_coef_loader;
  import color_corrector_csr_pkg::*;

  localparam logic [31:0] BASE = 32'h4000_0100;
  localparam int unsigned TMO  = 16;

  typedef struct packed { logic [31:0] a; logic [31:0] d; } wr_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0, start1 = 1'b0;
  logic [3:0]  coef_idx, idx1;
  logic [31:0] coef;
  logic        busy, done, err, busy1, done1, err1;

  axi4_lite_if csr ();
  axi4_lite_if csr1 ();

  always #5 clk = ~clk;
  assign coef = 32'h100 + {28'd0, coef_idx};

  cc_coef_loader #(.BASE_ADDR(BASE), .COEF_CNT(12), .TIMEOUT(TMO)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .coef_idx_o(coef_idx), .coef_i(coef),
    .busy_o(busy), .done_o(done), .err_o(err), .csr_o(csr));

  cc_coef_loader #(.COEF_CNT(1), .TIMEOUT(TMO)) dut1 (
    .clk_i(clk), .rst_i(rst), .start_i(start1), .coef_idx_o(idx1), .coef_i(32'hCAFE_0001),
    .busy_o(busy1), .done_o(done1), .err_o(err1), .csr_o(csr1));

  int n_chk = 0, n_pass = 0;
  function automatic void chk(string nm, logic [31:0] act, logic [31:0] expv);
    n_chk++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got 0x%h, expected 0x%h", nm, act, expv);
  endfunction

  function automatic logic [31:0] A(input int unsigned r);
    return BASE + 32'(r * 4);
  endfunction

  // ---------------- main slave model ----------------
  int          aw_dly = 0, w_dly = 0;
  bit          hang_b = 1'b0, err_sel4 = 1'b0;
  int          aw_wait, w_wait;
  logic        aw_got, w_got, bv;
  logic [1:0]  br;
  logic [31:0] aw_a, w_d;
  logic [31:0] regs [0:15];

  assign csr.awready = csr.awvalid && !aw_got && (aw_wait >= aw_dly);
  assign csr.wready  = csr.wvalid && !w_got && (w_wait >= w_dly);
  assign csr.bvalid  = bv;
  assign csr.bresp   = br;
  assign csr.arready = 1'b0;
  assign csr.rdata   = '0;
  assign csr.rresp   = 2'b00;
  assign csr.rvalid  = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      aw_got <= 1'b0; w_got <= 1'b0; bv <= 1'b0; br <= 2'b00;
      aw_wait <= 0; w_wait <= 0;
    end else begin
      if (csr.awvalid && !aw_got) aw_wait <= csr.awready ? 0 : aw_wait + 1;
      if (csr.awvalid && csr.awready) begin aw_got <= 1'b1; aw_a <= csr.awaddr; end
      if (csr.wvalid && !w_got) w_wait <= csr.wready ? 0 : w_wait + 1;
      if (csr.wvalid && csr.wready) begin w_got <= 1'b1; w_d <= csr.wdata; end
      if (bv && csr.bready) bv <= 1'b0;
      if (aw_got && w_got && !bv) begin
        aw_got <= 1'b0;
        w_got  <= 1'b0;
        regs[4'((aw_a - BASE) >> 2)] <= w_d;
        if (!hang_b) begin
          bv <= 1'b1;
          br <= (err_sel4 && aw_a == A(CC_COEF_SEL_CR) && w_d == 32'd4) ? 2'b10 : 2'b00;
        end
      end
    end
  end

  // ---------------- COEF_CNT=1 slave: always ready ----------------
  logic bv1;
  assign csr1.awready = 1'b1;
  assign csr1.wready  = 1'b1;
  assign csr1.bvalid  = bv1;
  assign csr1.bresp   = 2'b00;
  assign csr1.arready = 1'b0;
  assign csr1.rdata   = '0;
  assign csr1.rresp   = 2'b00;
  assign csr1.rvalid  = 1'b0;
  always @(posedge clk or posedge rst) begin
    if (rst) bv1 <= 1'b0;
    else if (csr1.awvalid && csr1.wvalid) bv1 <= 1'b1;
    else if (bv1 && csr1.bready) bv1 <= 1'b0;
  end

  // ---------------- scoreboard and monitors ----------------
  wr_t         exp_q[$], exp1_q[$];
  logic [31:0] aq[$], dq[$];
  int          n_wr = 0, n_done = 0, viol = 0, n1 = 0;
  logic        pav = 1'b0, pwv = 1'b0, aw_seen = 1'b0, w_seen = 1'b0;
  logic [31:0] paa, pwd, m_a, m_d;
  wr_t         m_e, m1_e;

  always @(negedge clk) begin
    if (rst) begin
      aq.delete(); dq.delete();
      pav = 1'b0; pwv = 1'b0; aw_seen = 1'b0; w_seen = 1'b0;
    end else begin
      if (pav && !(csr.awvalid && csr.awaddr == paa)) viol++;
      if (pwv && !(csr.wvalid && csr.wdata == pwd)) viol++;
      if (csr.bready && !(aw_seen && w_seen)) viol++;
      pav = csr.awvalid && !csr.awready; paa = csr.awaddr;
      pwv = csr.wvalid && !csr.wready;   pwd = csr.wdata;
      if (csr.awvalid && csr.awready) begin aq.push_back(csr.awaddr); aw_seen = 1'b1; end
      if (csr.wvalid && csr.wready)   begin dq.push_back(csr.wdata);  w_seen = 1'b1; end
      if ((csr.bvalid && csr.bready) || !busy) begin aw_seen = 1'b0; w_seen = 1'b0; end
      while (aq.size() > 0 && dq.size() > 0) begin
        m_a = aq.pop_front();
        m_d = dq.pop_front();
        n_wr++;
        if (exp_q.size() == 0) begin
          n_chk++;
          $display("FAIL unexpected write: addr 0x%h data 0x%h, none expected", m_a, m_d);
        end else begin
          m_e = exp_q.pop_front();
          chk("write addr", m_a, m_e.a);
          chk("write data", m_d, m_e.d);
        end
      end
      if (done) n_done++;
      if (csr1.awvalid && csr1.awready) begin
        n1++;
        if (exp1_q.size() == 0) begin
          n_chk++;
          $display("FAIL unexpected write (cnt1): addr 0x%h data 0x%h", csr1.awaddr, csr1.wdata);
        end else begin
          m1_e = exp1_q.pop_front();
          chk("cnt1 write addr", csr1.awaddr, m1_e.a);
          chk("cnt1 write data", csr1.wdata, m1_e.d);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic push_seq(input int n_idx, input bit fail_last_sel);
    exp_q.push_back('{a: A(CC_COEF_LOCK_CR), d: 32'd1});
    for (int i = 0; i < n_idx; i++) begin
      exp_q.push_back('{a: A(CC_COEF_SEL_CR), d: 32'(i)});
      if (!(fail_last_sel && i == n_idx - 1))
        exp_q.push_back('{a: A(CC_COEF_CR), d: 32'h100 + 32'(i)});
    end
    exp_q.push_back('{a: A(CC_COEF_LOCK_CR), d: 32'd0});
  endtask

  // start pulse at the current negedge; returns cycles until done_o is seen
  task automatic run_seq(input string nm, input int budget, input int restart_at,
                         output int cyc, output logic b1);
    cyc   = 0;
    b1    = 1'b0;
    start = 1'b1;
    while (cyc < budget) begin
      @(negedge clk);
      cyc++;
      start = (cyc == restart_at);
      if (cyc == 1) b1 = busy;
      if (done) break;
    end
    start = 1'b0;
    if (!done) begin
      n_chk++;
      $display("FAIL %s: done_o not seen within %0d cycles", nm, budget);
    end
  endtask

  int   cyc, w0, d0, v0, n10, k;
  logic b1;

  initial begin
    repeat (3) @(negedge clk);
    chk("rst awvalid", 32'(csr.awvalid), 0);
    chk("rst wvalid", 32'(csr.wvalid), 0);
    chk("rst bready", 32'(csr.bready), 0);
    chk("rst busy", 32'(busy), 0);
    chk("rst done", 32'(done), 0);
    chk("rst err", 32'(err), 0);
    chk("rst coef_idx", 32'(coef_idx), 0);
    chk("rst awaddr", csr.awaddr, 0);
    chk("rst wdata", csr.wdata, 0);
    chk("tie arvalid", 32'(csr.arvalid), 0);
    chk("tie araddr", csr.araddr, 0);
    chk("tie rready", 32'(csr.rready), 1);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // zero-wait full load, with a second start pulse mid-sequence
    w0 = n_wr; d0 = n_done; v0 = viol;
    push_seq(12, 1'b0);
    run_seq("full", 400, 10, cyc, b1);
    chk("busy after start", 32'(b1), 1);
    chk("busy in FIN", 32'(busy), 1);
    repeat (4) @(negedge clk);
    chk("full writes", 32'(n_wr - w0), 26);
    chk("full done pulses", 32'(n_done - d0), 1);
    chk("full err", 32'(err), 0);
    chk("full busy idle", 32'(busy), 0);
    chk("full coef reg", regs[CC_COEF_CR], 32'h10B);
    chk("full lock reg", regs[CC_COEF_LOCK_CR], 0);
    chk("full protocol", 32'(viol - v0), 0);
    chk("full drained", 32'(exp_q.size()), 0);

    // aw late, then w late
    for (int p = 0; p < 2; p++) begin
      aw_dly = (p == 0) ? 3 : 0;
      w_dly  = (p == 0) ? 0 : 3;
      w0 = n_wr; d0 = n_done; v0 = viol;
      push_seq(12, 1'b0);
      run_seq("skew", 1200, 0, cyc, b1);
      repeat (3) @(negedge clk);
      chk("skew writes", 32'(n_wr - w0), 26);
      chk("skew done pulses", 32'(n_done - d0), 1);
      chk("skew protocol", 32'(viol - v0), 0);
      chk("skew drained", 32'(exp_q.size()), 0);
    end
    aw_dly = 0; w_dly = 0;

    // SLVERR on SEL of index 4
    err_sel4 = 1'b1;
    w0 = n_wr; d0 = n_done; v0 = viol;
    push_seq(5, 1'b1);
    run_seq("slverr", 400, 0, cyc, b1);
    repeat (5) @(negedge clk);
    chk("slverr writes", 32'(n_wr - w0), 11);
    chk("slverr done pulses", 32'(n_done - d0), 1);
    chk("slverr err sticky", 32'(err), 1);
    chk("slverr coef reg", regs[CC_COEF_CR], 32'h103);
    chk("slverr drained", 32'(exp_q.size()), 0);
    err_sel4 = 1'b0;

    // no write response at all: LOCK_ON and LOCK_OFF both time out
    hang_b = 1'b1;
    w0 = n_wr; d0 = n_done;
    exp_q.push_back('{a: A(CC_COEF_LOCK_CR), d: 32'd1});
    exp_q.push_back('{a: A(CC_COEF_LOCK_CR), d: 32'd0});
    run_seq("timeout", 200, 0, cyc, b1);
    chk("timeout cycles to done", 32'(cyc), 35);
    repeat (3) @(negedge clk);
    chk("timeout err", 32'(err), 1);
    chk("timeout writes", 32'(n_wr - w0), 2);
    chk("timeout done pulses", 32'(n_done - d0), 1);
    chk("timeout drained", 32'(exp_q.size()), 0);
    hang_b = 1'b0;

    // COEF_CNT = 1
    n10 = n1;
    exp1_q.push_back('{a: 32'(CC_COEF_LOCK_CR * 4), d: 32'd1});
    exp1_q.push_back('{a: 32'(CC_COEF_SEL_CR * 4),  d: 32'd0});
    exp1_q.push_back('{a: 32'(CC_COEF_CR * 4),      d: 32'hCAFE_0001});
    exp1_q.push_back('{a: 32'(CC_COEF_LOCK_CR * 4), d: 32'd0});
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    k = 0;
    while (!done1 && k < 100) begin @(negedge clk); k++; end
    if (!done1) begin n_chk++; $display("FAIL cnt1: done_o not seen within 100 cycles"); end
    repeat (3) @(negedge clk);
    chk("cnt1 writes", 32'(n1 - n10), 4);
    chk("cnt1 err", 32'(err1), 0);
    chk("cnt1 drained", 32'(exp1_q.size()), 0);

    // reset while a COEF write is outstanding
    aw_dly = 2;
    w0 = n_wr;
    exp_q.push_back('{a: A(CC_COEF_LOCK_CR), d: 32'd1});
    exp_q.push_back('{a: A(CC_COEF_SEL_CR),  d: 32'd0});
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("err cleared on start", 32'(err), 0);
    k = 0;
    while (!(csr.awvalid && csr.awaddr == A(CC_COEF_CR)) && k < 100) begin @(negedge clk); k++; end
    if (k >= 100) begin n_chk++; $display("FAIL reset: COEF write never launched"); end
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("mid rst awvalid", 32'(csr.awvalid), 0);
    chk("mid rst wvalid", 32'(csr.wvalid), 0);
    chk("mid rst bready", 32'(csr.bready), 0);
    chk("mid rst busy", 32'(busy), 0);
    chk("mid rst coef_idx", 32'(coef_idx), 0);
    chk("mid rst done", 32'(done), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    aw_dly = 0;
    repeat (20) @(negedge clk);
    chk("no resume writes", 32'(n_wr - w0), 2);
    chk("no resume busy", 32'(busy), 0);
    chk("reset drained", 32'(exp_q.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
